// File: rtl/ext_reg_pkg.sv
// Shared definitions for the external register initiator.
// Holds the transaction FSM state encoding and the timeout counter width.
// No logic; imported by ext_reg_initiator and ext_reg_timer.
package ext_reg_pkg;

    // Width of the ack timeout counter; TIMEOUT must fit (2..255).
    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/ext_reg_timer.sv
// Ack timeout counter: counts cycles spent waiting for an external ack.
// Latency: expired is combinational on the cycle the count would reach LIMIT.
// Backpressure: none; clear has priority over enable.
//
// Ports: clk, rst (sync active-low), clear (force count to 0),
//        enable (count this cycle), expired (this enabled cycle is the LIMIT-th).
module ext_reg_timer
    import ext_reg_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The count "reaches" LIMIT on the edge that ends this cycle.
    assign expired = enable && (cnt == TMR_W'(LIMIT - 1));

endmodule

// File: rtl/ext_reg_initiator.sv
// Bridges a CPU register request to a one-hot external register request and
// returns the external ack (or a timeout/range error) to the CPU.
// Latency: req one cycle after accept; CPU ack one cycle after the external ack.
// Backpressure: cpu_req_stall is high whenever a transaction is outstanding.
//
// Ports: clk, rst (sync active-low);
//        CPU side   cpu_req/cpu_req_is_wr/cpu_subword/cpu_wr_data/cpu_wr_biten in,
//                   cpu_req_stall, cpu_rd_ack/err/data, cpu_wr_ack/err out;
//        external   req (one-hot per subword), req_is_wr, wr_data, wr_biten out,
//                   rd_ack/rd_data, wr_ack in.
module ext_reg_initiator
    import ext_reg_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int SUBWORDS = 1,
    parameter  int TIMEOUT  = 16,
    localparam int IW       = (SUBWORDS > 1) ? $clog2(SUBWORDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_req_is_wr,
    input  logic [IW-1:0]       cpu_subword,
    input  logic [WIDTH-1:0]    cpu_wr_data,
    input  logic [WIDTH-1:0]    cpu_wr_biten,
    output logic                cpu_req_stall,
    output logic                cpu_rd_ack,
    output logic                cpu_rd_err,
    output logic [WIDTH-1:0]    cpu_rd_data,
    output logic                cpu_wr_ack,
    output logic                cpu_wr_err,
    output logic [SUBWORDS-1:0] req,
    output logic                req_is_wr,
    output logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    wr_biten,
    input  logic                rd_ack,
    input  logic [WIDTH-1:0]    rd_data,
    input  logic                wr_ack
);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                sub_ok;
    logic                ack_match;
    logic [SUBWORDS-1:0] req_onehot;
    logic                resp_vld;
    logic                resp_wr;
    logic                resp_err;
    logic                tmr_clear;
    logic                tmr_enable;
    logic                tmr_expired;

    // Subword decode; an out-of-range index never reaches the external side.
    always_comb begin
        req_onehot = '0;
        for (int i = 0; i < SUBWORDS; i++) begin
            req_onehot[i] = (cpu_subword == IW'(i));
        end
        sub_ok = (32'(cpu_subword) < 32'(SUBWORDS));
    end

    // req_is_wr doubles as the captured direction of the outstanding request.
    assign ack_match = req_is_wr ? wr_ack : rd_ack;

    // Counter is held at zero outside WAIT so every WAIT starts from 0.
    assign tmr_clear = (state != ST_WAIT);

    ext_reg_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        resp_vld   = 1'b0;
        resp_wr    = req_is_wr;
        resp_err   = 1'b0;
        tmr_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    accept = 1'b1;
                    if (sub_ok) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        // Bad subword: answer immediately with an error.
                        state_nxt = ST_RESP;
                        resp_vld  = 1'b1;
                        resp_wr   = cpu_req_is_wr;
                        resp_err  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Ack beats the timeout when both land on the same cycle.
                tmr_enable = !ack_match;
                if (ack_match) begin
                    state_nxt = ST_RESP;
                    resp_vld  = 1'b1;
                end else if (tmr_expired) begin
                    state_nxt = ST_RESP;
                    resp_vld  = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // All outputs are registered from next-state decisions so they line up
    // with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cpu_req_stall <= 1'b0;
            req           <= '0;
            req_is_wr     <= 1'b0;
            wr_data       <= '0;
            wr_biten      <= '0;
            cpu_rd_ack    <= 1'b0;
            cpu_rd_err    <= 1'b0;
            cpu_rd_data   <= '0;
            cpu_wr_ack    <= 1'b0;
            cpu_wr_err    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cpu_req_stall <= (state_nxt != ST_IDLE);
            // req is the captured subword, visible only for the ISSUE cycle.
            req           <= (accept && sub_ok) ? req_onehot : '0;
            if (accept) begin
                req_is_wr <= cpu_req_is_wr;
                wr_data   <= cpu_wr_data;
                wr_biten  <= cpu_wr_biten;
            end
            cpu_rd_ack    <= resp_vld && !resp_wr;
            cpu_rd_err    <= resp_vld && !resp_wr && resp_err;
            cpu_rd_data   <= (resp_vld && !resp_wr && !resp_err) ? rd_data : '0;
            cpu_wr_ack    <= resp_vld && resp_wr;
            cpu_wr_err    <= resp_vld && resp_wr && resp_err;
        end
    end

endmodule

// File: tb/tb_ext_reg_initiator.sv
// Self-checking bench for ext_reg_initiator.
// Five subwords are used so that index 5 is representable yet out of range.
// Expected timing comes from a per-transaction model of accept-relative cycles.
module tb_ext_reg_initiator;

    localparam int WIDTH    = 32;
    localparam int SUBWORDS = 5;
    localparam int TIMEOUT  = 16;
    localparam int IW       = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cpu_req = 1'b0;
    logic                cpu_req_is_wr = 1'b0;
    logic [IW-1:0]       cpu_subword = '0;
    logic [WIDTH-1:0]    cpu_wr_data = '0;
    logic [WIDTH-1:0]    cpu_wr_biten = '0;
    logic                cpu_req_stall;
    logic                cpu_rd_ack;
    logic                cpu_rd_err;
    logic [WIDTH-1:0]    cpu_rd_data;
    logic                cpu_wr_ack;
    logic                cpu_wr_err;
    logic [SUBWORDS-1:0] req;
    logic                req_is_wr;
    logic [WIDTH-1:0]    wr_data;
    logic [WIDTH-1:0]    wr_biten;
    logic                rd_ack = 1'b0;
    logic [WIDTH-1:0]    rd_data = '0;
    logic                wr_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_reg_initiator #(
        .WIDTH    (WIDTH),
        .SUBWORDS (SUBWORDS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_req_is_wr (cpu_req_is_wr),
        .cpu_subword   (cpu_subword),
        .cpu_wr_data   (cpu_wr_data),
        .cpu_wr_biten  (cpu_wr_biten),
        .cpu_req_stall (cpu_req_stall),
        .cpu_rd_ack    (cpu_rd_ack),
        .cpu_rd_err    (cpu_rd_err),
        .cpu_rd_data   (cpu_rd_data),
        .cpu_wr_ack    (cpu_wr_ack),
        .cpu_wr_err    (cpu_wr_err),
        .req           (req),
        .req_is_wr     (req_is_wr),
        .wr_data       (wr_data),
        .wr_biten      (wr_biten),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .wr_ack        (wr_ack)
    );

    // One CPU transaction. The responder asserts the matching ack d cycles
    // after the req cycle; optional extras: a wrong-direction ack two cycles
    // before it, a matching ack during the req cycle, and busy-time requests.
    // The model: response at accept+2+d if d<=TIMEOUT, else accept+TIMEOUT+2
    // with error; out-of-range subword responds at accept+1 with error.
    task automatic run_txn(input bit is_wr, input logic [IW-1:0] sub,
                           input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] biten,
                           input int d, input logic [WIDTH-1:0] rdval,
                           input bit wrong, input bit early, input bit noise,
                           input string name);
        bit                  bad;
        bit                  exp_err;
        int                  exp_k;
        int                  kmax;
        logic [WIDTH-1:0]    exp_data;
        logic [SUBWORDS-1:0] exp_oh;
        logic [SUBWORDS-1:0] exp_req;
        logic [WIDTH-1:0]    exp_rdd;
        bit                  exp_rack;
        bit                  exp_wack;
        bit                  exp_stall;
        bit                  got_err;

        bad = (int'(sub) >= SUBWORDS);
        if (bad) begin
            exp_k = 1;
            exp_err = 1'b1;
        end else if (d <= TIMEOUT) begin
            exp_k = d + 2;
            exp_err = 1'b0;
        end else begin
            exp_k = TIMEOUT + 2;
            exp_err = 1'b1;
        end
        exp_data = (!is_wr && !exp_err) ? rdval : '0;
        exp_oh   = bad ? '0 : (SUBWORDS'(1) << sub);
        kmax     = (((d + 1) > exp_k) ? (d + 1) : exp_k) + 3;

        @(posedge clk);
        #1;
        cpu_req       = 1'b1;
        cpu_req_is_wr = is_wr;
        cpu_subword   = sub;
        cpu_wr_data   = data;
        cpu_wr_biten  = biten;
        @(negedge clk);
        checks++;
        if (cpu_req_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_stall got %b exp 0", name, cpu_req_stall);
        end
        @(posedge clk);

        for (int k = 1; k <= kmax; k++) begin
            #1;
            if (noise && k <= exp_k) begin
                cpu_req       = 1'b1;
                cpu_req_is_wr = 1'($urandom);
                cpu_subword   = IW'($urandom);
                cpu_wr_data   = $urandom;
                cpu_wr_biten  = $urandom;
            end else begin
                cpu_req = 1'b0;
            end
            rd_ack = 1'b0;
            wr_ack = 1'b0;
            if (k == d + 1) begin
                if (is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
            end else if (wrong && d >= 3 && k == d - 1) begin
                if (is_wr) rd_ack = 1'b1; else wr_ack = 1'b1;
            end else if (early && k == 1) begin
                if (is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
            end
            rd_data = rd_ack ? rdval : $urandom;

            @(negedge clk);
            exp_req   = (k == 1) ? exp_oh : '0;
            exp_stall = (k <= exp_k);
            exp_rack  = (k == exp_k) && !is_wr;
            exp_wack  = (k == exp_k) && is_wr;
            exp_rdd   = exp_rack ? exp_data : '0;

            checks++;
            if (req !== exp_req) begin
                errors++;
                $display("FAIL %s req k=%0d got %b exp %b", name, k, req, exp_req);
            end
            checks++;
            if (cpu_req_stall !== exp_stall) begin
                errors++;
                $display("FAIL %s stall k=%0d got %b exp %b", name, k, cpu_req_stall, exp_stall);
            end
            checks++;
            if (cpu_rd_ack !== exp_rack) begin
                errors++;
                $display("FAIL %s cpu_rd_ack k=%0d got %b exp %b", name, k, cpu_rd_ack, exp_rack);
            end
            checks++;
            if (cpu_wr_ack !== exp_wack) begin
                errors++;
                $display("FAIL %s cpu_wr_ack k=%0d got %b exp %b", name, k, cpu_wr_ack, exp_wack);
            end
            checks++;
            if (cpu_rd_data !== exp_rdd) begin
                errors++;
                $display("FAIL %s cpu_rd_data k=%0d got %h exp %h", name, k, cpu_rd_data, exp_rdd);
            end
            if (k == exp_k) begin
                got_err = is_wr ? cpu_wr_err : cpu_rd_err;
                checks++;
                if (got_err !== exp_err) begin
                    errors++;
                    $display("FAIL %s err k=%0d got %b exp %b", name, k, got_err, exp_err);
                end
            end
            if (!bad) begin
                checks++;
                if ({req_is_wr, wr_data, wr_biten} !== {is_wr, data, biten}) begin
                    errors++;
                    $display("FAIL %s ext_hold k=%0d got %b/%h/%h exp %b/%h/%h",
                             name, k, req_is_wr, wr_data, wr_biten, is_wr, data, biten);
                end
            end
            @(posedge clk);
        end
        #1;
        cpu_req = 1'b0;
        rd_ack  = 1'b0;
        wr_ack  = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        cpu_req       = 1'b1;
        cpu_req_is_wr = 1'b1;
        cpu_subword   = 3'd1;
        cpu_wr_data   = 32'hDEAD_BEEF;
        cpu_wr_biten  = 32'hFFFF_FFFF;
        rd_ack        = 1'b1;
        wr_ack        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req !== '0 || req_is_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got %b/%b exp 0/0", req, req_is_wr);
        end
        checks++;
        if (wr_data !== '0 || wr_biten !== '0) begin
            errors++;
            $display("FAIL reset_wr got %h/%h exp 0/0", wr_data, wr_biten);
        end
        checks++;
        if ({cpu_rd_ack, cpu_rd_err, cpu_wr_ack, cpu_wr_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_acks got %b exp 0000",
                     {cpu_rd_ack, cpu_rd_err, cpu_wr_ack, cpu_wr_err});
        end
        checks++;
        if (cpu_rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_data got %h exp 0", cpu_rd_data);
        end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        cpu_req = 1'b0;
        rd_ack  = 1'b0;
        wr_ack  = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_req_stall !== 1'b0 || req !== '0) begin
            errors++;
            $display("FAIL reset_release got stall=%b req=%b exp 0/0", cpu_req_stall, req);
        end
    endtask

    task automatic test_write_basic();
        run_txn(1'b1, 3'd2, 32'hA5A5_0000, 32'hFFFF_0000, 3, 32'h0, 1'b0, 1'b0, 1'b0, "wr_sub2_d3");
    endtask

    task automatic test_read_basic();
        run_txn(1'b0, 3'd0, 32'h0, 32'h0, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "rd_d1");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 3'd3, 32'h0, 32'h0, 19, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, "rd_timeout_late_ack");
        run_txn(1'b0, 3'd4, 32'h0, 32'h0, TIMEOUT, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0, "rd_ack_at_limit");
        run_txn(1'b1, 3'd1, 32'h1111_2222, 32'h0F0F_0F0F, TIMEOUT + 1, 32'h0, 1'b0, 1'b0, 1'b0, "wr_ack_one_late");
    endtask

    task automatic test_wrong_ack();
        run_txn(1'b0, 3'd1, 32'h0, 32'h0, 4, 32'h5566_7788, 1'b1, 1'b0, 1'b0, "rd_wrong_ack_first");
        run_txn(1'b1, 3'd3, 32'h0000_ABCD, 32'h0000_FFFF, 5, 32'h0, 1'b1, 1'b1, 1'b0, "wr_wrong_and_early");
    endtask

    task automatic test_bad_subword();
        run_txn(1'b1, 3'd5, 32'h1357_9BDF, 32'hFFFF_FFFF, 2, 32'h0, 1'b0, 1'b0, 1'b0, "wr_sub5");
        run_txn(1'b0, 3'd7, 32'h0, 32'h0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "rd_sub7");
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        cpu_req       = 1'b1;
        cpu_req_is_wr = 1'b0;
        cpu_subword   = 3'd1;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        rd_ack  = 1'b1;
        rd_data = 32'h7777_8888;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({cpu_rd_ack, cpu_wr_ack, cpu_req_stall} !== 3'b000 || req !== '0) begin
                errors++;
                $display("FAIL reset_mid k=%0d got rd_ack=%b wr_ack=%b stall=%b req=%b exp 0",
                         k, cpu_rd_ack, cpu_wr_ack, cpu_req_stall, req);
            end
            @(posedge clk);
            #1;
            rd_ack = 1'b0;
        end
        run_txn(1'b0, 3'd1, 32'h0, 32'h0, 2, 32'h2468_ACE0, 1'b0, 1'b0, 1'b0, "rd_after_reset");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 3'd4, 32'hFEED_0001, 32'hFFFF_FFFF, 1, 32'h0, 1'b0, 1'b0, 1'b1, "b2b_wr");
        run_txn(1'b0, 3'd0, 32'h0, 32'h0, 1, 32'hFEED_0002, 1'b0, 1'b0, 1'b1, "b2b_rd");
        run_txn(1'b1, 3'd6, 32'hFEED_0003, 32'h0, 1, 32'h0, 1'b0, 1'b0, 1'b1, "b2b_bad");
    endtask

    task automatic test_random();
        bit               is_wr;
        logic [IW-1:0]    sub;
        int               d;
        int               r;
        for (int i = 0; i < 40; i++) begin
            is_wr = 1'($urandom);
            sub   = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(5, 7))
                                                : IW'($urandom_range(0, 4));
            r     = $urandom_range(0, 9);
            d     = (r < 7) ? $urandom_range(1, 6) : $urandom_range(14, 20);
            run_txn(is_wr, sub, $urandom, $urandom, d, $urandom,
                    1'($urandom), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_timeout();
        test_wrong_ack();
        test_bad_subword();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
